// File: rtl/pc_fetch_gen_pkg.sv
// Shared types and constants for the PC fetch generator.
//   fetch_state_e : generator FSM states (boot, run, run-with-pending-redirect)
//   redir_prio_e  : redirect priority code, ordered so a larger value wins
//   Def*          : default reset/exception vectors and sequential increment
package pc_fetch_gen_pkg;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } fetch_state_e;

    // Exceptions are never stored, so they have no code here.
    typedef enum logic [1:0] {
        PrioNone = 2'd0,
        PrioJmp  = 2'd1,
        PrioBr   = 2'd2,
        PrioEret = 2'd3
    } redir_prio_e;

    localparam logic [31:0] DefResetVector = 32'hbfc00000;
    localparam logic [31:0] DefExcVector   = 32'hbfc00380;
    localparam int unsigned DefInc         = 4;

endpackage

// File: rtl/pc_fetch_gen_if.sv
// Fetch-generator bus: redirect requests in, fetch address and status out.
//   master : the PC generator (drives pc, pc_plus_inc, pc_valid, fetch_misaligned,
//            redirect_pending; samples fetch_ready, stall and redirect requests)
//   slave  : the surrounding pipeline (the reverse directions)
interface pc_fetch_gen_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              fetch_ready;
    logic              stall;
    logic              exc_req;
    logic              eret_req;
    logic [ADDR_W-1:0] epc;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              jmp_req;
    logic [ADDR_W-1:0] jmp_target;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus_inc;
    logic              pc_valid;
    logic              fetch_misaligned;
    logic              redirect_pending;

    modport master (
        input  fetch_ready, stall, exc_req, eret_req, epc, br_taken, br_target,
               jmp_req, jmp_target,
        output pc, pc_plus_inc, pc_valid, fetch_misaligned, redirect_pending
    );

    modport slave (
        output fetch_ready, stall, exc_req, eret_req, epc, br_taken, br_target,
               jmp_req, jmp_target,
        input  pc, pc_plus_inc, pc_valid, fetch_misaligned, redirect_pending
    );
endinterface

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter.
//   eret/br/jmp inputs : live (this-cycle) redirect requests and their targets
//   pend_*_i           : the stored pending redirect
//   live_*_o           : highest-priority live request (eret > br > jmp)
//   sel_*_o            : winner of live vs pending; the live request wins ties
module pc_redirect_arb
    import pc_fetch_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              eret_req_i,
    input  logic [ADDR_W-1:0] epc_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              jmp_req_i,
    input  logic [ADDR_W-1:0] jmp_target_i,
    input  redir_prio_e       pend_prio_i,
    input  logic [ADDR_W-1:0] pend_target_i,
    output redir_prio_e       live_prio_o,
    output logic [ADDR_W-1:0] live_target_o,
    output redir_prio_e       sel_prio_o,
    output logic [ADDR_W-1:0] sel_target_o
);

    redir_prio_e       live_prio;
    logic [ADDR_W-1:0] live_target;

    always_comb begin
        live_prio   = PrioNone;
        live_target = '0;
        if (eret_req_i) begin
            live_prio   = PrioEret;
            live_target = epc_i;
        end else if (br_taken_i) begin
            live_prio   = PrioBr;
            live_target = br_target_i;
        end else if (jmp_req_i) begin
            live_prio   = PrioJmp;
            live_target = jmp_target_i;
        end
    end

    always_comb begin
        sel_prio_o   = pend_prio_i;
        sel_target_o = pend_target_i;
        if (live_prio != PrioNone && live_prio >= pend_prio_i) begin
            sel_prio_o   = live_prio;
            sel_target_o = live_target;
        end
    end

    assign live_prio_o   = live_prio;
    assign live_target_o = live_target;

endmodule

// File: rtl/pc_fetch_gen.sv
// PC fetch generator: produces the instruction fetch address, stepping by INC or
// redirecting on exception / eret / branch / jump. Redirects that arrive while
// the PC cannot advance are held in a single pending slot until the next advance.
//   clk, reset : clock and synchronous active-high reset
//   bus        : pc_fetch_gen_if master modport (requests in, pc and status out)
module pc_fetch_gen
    import pc_fetch_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DefResetVector),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DefExcVector),
    parameter int unsigned       INC          = DefInc
) (
    input logic            clk,
    input logic            reset,
    pc_fetch_gen_if.master bus
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    redir_prio_e       pend_prio_q, pend_prio_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;

    redir_prio_e       live_prio, sel_prio;
    logic [ADDR_W-1:0] live_target, sel_target;
    logic              pc_valid;
    logic [ADDR_W-1:0] pc_plus_inc;
    logic              advance;

    pc_redirect_arb #(
        .ADDR_W (ADDR_W)
    ) u_arb (
        .eret_req_i    (bus.eret_req),
        .epc_i         (bus.epc),
        .br_taken_i    (bus.br_taken),
        .br_target_i   (bus.br_target),
        .jmp_req_i     (bus.jmp_req),
        .jmp_target_i  (bus.jmp_target),
        .pend_prio_i   (pend_prio_q),
        .pend_target_i (pend_target_q),
        .live_prio_o   (live_prio),
        .live_target_o (live_target),
        .sel_prio_o    (sel_prio),
        .sel_target_o  (sel_target)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StBoot;
            pc_q          <= RESET_VECTOR;
            pend_prio_q   <= PrioNone;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_prio_q   <= pend_prio_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign advance = pc_valid & bus.fetch_ready & ~bus.stall;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_prio_d   = pend_prio_q;
        pend_target_d = pend_target_q;
        if (bus.exc_req) begin
            // Exceptions ignore stall/ready and flush whatever was pending.
            state_d       = StRun;
            pc_d          = EXC_VECTOR;
            pend_prio_d   = PrioNone;
            pend_target_d = '0;
        end else if (state_q == StBoot) begin
            // Non-exception redirects during boot are dropped.
            state_d = StRun;
        end else if (advance) begin
            state_d       = StRun;
            pc_d          = (sel_prio != PrioNone) ? sel_target : pc_plus_inc;
            pend_prio_d   = PrioNone;
            pend_target_d = '0;
        end else if (live_prio != PrioNone && live_prio >= pend_prio_q) begin
            state_d       = StHold;
            pend_prio_d   = live_prio;
            pend_target_d = live_target;
        end
    end

    always_comb begin
        pc_valid             = (state_q != StBoot);
        pc_plus_inc          = pc_q + ADDR_W'(INC);
        bus.pc               = pc_q;
        bus.pc_plus_inc      = pc_plus_inc;
        bus.pc_valid         = pc_valid;
        bus.fetch_misaligned = pc_valid & (pc_q[1:0] != 2'b00);
        bus.redirect_pending = (state_q == StHold);
    end

endmodule
